seq_alu: RTL

- Registered, parametrised-width ALU with valid/ready handshakes on input and output.
- Single-cycle ops (add, sub, and, or, xor, slt) complete in one clock.
- Shifts run iteratively, one bit per cycle, so a variable shift amount needs no barrel shifter.
- Sits between the operand/decode stage and writeback; carries the codebase flag set (zeroFlag, overflowFlag, carryoutFlag, negativeFlag) alongside each result.

---
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Handshake and payload bundle between the operand stage, seq_alu and writeback.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zeroFlag;
  logic             overflowFlag;
  logic             carryoutFlag;
  logic             negativeFlag;

  // Producer/consumer side: drives operands and out_ready.
  modport master (
    output in_valid, a, b, control, out_ready,
    input  in_ready, out_valid, out, zeroFlag, overflowFlag, carryoutFlag, negativeFlag
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, control, out_ready,
    output in_ready, out_valid, out, zeroFlag, overflowFlag, carryoutFlag, negativeFlag
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle logic/arithmetic, iterative one-bit-per-cycle shifts.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  seq_alu_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic             r_sra;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_ovf;
  logic             r_carry;
  logic             r_neg;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [SHW-1:0]   w_cnt_nxt;
  logic             w_sra_nxt;
  logic             w_upd;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_n;
  logic [WIDTH-1:0] w_acc_sh;
  logic             w_c_sh;
  logic             w_lt;

  // Next-state, datapath step and result selection.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_sra_nxt   = r_sra;
    w_upd       = 1'b0;
    w_res       = r_out;
    w_c         = 1'b0;
    w_v         = 1'b0;
    w_sum       = {1'b0, bus.a} + {1'b0, bus.b};
    w_diff      = {1'b0, bus.a} - {1'b0, bus.b};
    w_n         = bus.b[SHW-1:0];
    w_lt        = ($signed(bus.a) < $signed(bus.b));
    // One-bit shift step; the bit leaving the accumulator becomes the carry.
    if (r_sra) begin
      w_acc_sh = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      w_c_sh   = r_acc[0];
    end else begin
      w_acc_sh = {r_acc[WIDTH-2:0], 1'b0};
      w_c_sh   = r_acc[WIDTH-1];
    end

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.control[2:1] == 2'b11) begin
            if (w_n == '0) begin
              w_res       = bus.a;
              w_upd       = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_acc_nxt   = bus.a;
              w_cnt_nxt   = w_n;
              w_sra_nxt   = bus.control[0];
              w_state_nxt = S_SHIFT;
            end
          end else begin
            w_upd       = 1'b1;
            w_state_nxt = S_HOLD;
            case (bus.control)
              OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
              end
              OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
              end
              OP_AND:  w_res = bus.a & bus.b;
              OP_OR:   w_res = bus.a | bus.b;
              OP_XOR:  w_res = bus.a ^ bus.b;
              OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
              default: w_res = '0;
            endcase
          end
        end
      end
      S_SHIFT: begin
        w_acc_nxt = w_acc_sh;
        w_cnt_nxt = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          w_res       = w_acc_sh;
          w_c         = w_c_sh;
          w_upd       = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, shift accumulator and result/flag registers; reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sra   <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sra   <= w_sra_nxt;
      if (w_upd) begin
        r_out   <= w_res;
        r_zero  <= (w_res == '0);
        r_ovf   <= w_v;
        r_carry <= w_c;
        r_neg   <= w_res[WIDTH-1];
      end
    end
  end

  assign bus.in_ready     = (r_state == S_IDLE);
  assign bus.out_valid    = (r_state == S_HOLD);
  assign bus.out          = r_out;
  assign bus.zeroFlag     = r_zero;
  assign bus.overflowFlag = r_ovf;
  assign bus.carryoutFlag = r_carry;
  assign bus.negativeFlag = r_neg;
endmodule
